// File: rtl/prog_loader.sv
// prog_loader: loads a little-endian program image from a byte stream into
// instruction memory. It holds the processor in reset while the memory
// contents are being replaced or are known to be incomplete.
module prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    // Largest legal word count: the whole memory, so addresses never wrap.
    localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        byte_cnt_reg, byte_cnt_next;
    logic [7:0]        hdr_lo_reg, hdr_lo_next;
    logic [15:0]       n_reg, n_next;
    logic [ADDR_W-1:0] word_idx_reg, word_idx_next;
    logic [31:0]       asm_reg, asm_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;

    logic        xfer;
    logic [16:0] n_hdr;
    logic [16:0] idx_plus1;
    logic        last_word;
    logic        timed_out;

    assign xfer      = rx_valid && rx_ready;
    // Header count as it will be once the high byte now on rx_data is taken.
    assign n_hdr     = {1'b0, rx_data, hdr_lo_reg};
    assign idx_plus1 = 17'(word_idx_reg) + 17'd1;
    assign last_word = (idx_plus1 == {1'b0, n_reg});
    // The idle cycle now in progress is the one that reaches TIMEOUT.
    assign timed_out = (to_cnt_reg == TO_W'(TIMEOUT - 1));

    // The write port simply exposes the current word index and assembled
    // word; they only matter while mem_we is high.
    assign mem_addr  = word_idx_reg;
    assign mem_wdata = asm_reg;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            hdr_lo_reg   <= '0;
            n_reg        <= '0;
            word_idx_reg <= '0;
            asm_reg      <= '0;
            to_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            hdr_lo_reg   <= hdr_lo_next;
            n_reg        <= n_next;
            word_idx_reg <= word_idx_next;
            asm_reg      <= asm_next;
            to_cnt_reg   <= to_cnt_next;
        end
    end

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        hdr_lo_next   = hdr_lo_reg;
        n_next        = n_reg;
        word_idx_next = word_idx_reg;
        asm_next      = asm_reg;
        to_cnt_next   = to_cnt_reg;
        rx_ready      = 1'b0;
        mem_we        = 1'b0;
        busy          = 1'b0;
        cpu_rst       = 1'b0;
        done          = 1'b0;
        err           = 1'b0;

        case (state_reg)
            IDLE, DONE, ERR: begin
                done    = (state_reg == DONE);
                err     = (state_reg == ERR);
                cpu_rst = (state_reg == ERR);
                if (start) begin
                    state_next    = HDR;
                    byte_cnt_next = '0;
                    word_idx_next = '0;
                    to_cnt_next   = '0;
                end
            end
            HDR: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_rst  = 1'b1;
                if (xfer) begin
                    to_cnt_next = '0;
                    if (byte_cnt_reg == 2'd0) begin
                        hdr_lo_next   = rx_data;
                        byte_cnt_next = 2'd1;
                    end else begin
                        n_next        = n_hdr[15:0];
                        byte_cnt_next = 2'd0;
                        if (n_hdr == 17'd0 || n_hdr > MAX_N) begin
                            state_next = ERR;
                        end else begin
                            state_next = DATA;
                        end
                    end
                end else if (timed_out) begin
                    state_next = ERR;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_rst  = 1'b1;
                if (xfer) begin
                    to_cnt_next = '0;
                    // First byte of a word ends up in bits 7:0 after four shifts.
                    asm_next    = {rx_data, asm_reg[31:8]};
                    if (byte_cnt_reg == 2'd3) begin
                        byte_cnt_next = 2'd0;
                        state_next    = WRITE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                    end
                end else if (timed_out) begin
                    state_next = ERR;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                busy    = 1'b1;
                cpu_rst = 1'b1;
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    word_idx_next = word_idx_reg + ADDR_W'(1);
                    state_next    = DATA;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: expected memory writes are queued by the
// stimulus tasks and checked by an independent write monitor.
module tb_prog_loader;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] fixed_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          byte_no  = 0;
    int          glitch_at = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    // Write monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=0x%08h required=no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (int'(mem_addr) != e.addr || mem_wdata !== e.data) begin
                    failures++;
                    $display("FAIL write addr=%0d data=0x%08h required addr=%0d data=0x%08h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end else if (e.addr < 4 || e.addr % 256 == 0) begin
                    $display("ok   write addr=%0d data=0x%08h", mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        byte_no = 0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_flags", {30'd0, done, err}, 32'd0);
    endtask

    // Offer one byte after a random idle gap and wait for it to be accepted.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  gap;
        int  guard;
        bit  took;
        gap   = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        guard = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (byte_no == glitch_at) start = 1'b1;
        do begin
            took = rx_ready;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            guard++;
        end while (!took && guard < 64);
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout byte=%0d actual=not accepted required=accepted", byte_no);
        end
        rx_valid = 1'b0;
        byte_no++;
    endtask

    // Complete load of n words; words come from fixed_q when use_fixed is set.
    task automatic run_load(input int n, input int max_gap, input bit use_fixed);
        logic [31:0] w;
        logic [15:0] nn;
        nn = 16'(n);
        pulse_start();
        send_byte(nn[7:0], max_gap);
        send_byte(nn[15:8], max_gap);
        for (int i = 0; i < n; i++) begin
            w = use_fixed ? fixed_q[i] : $urandom;
            exp_q.push_back('{i, w});
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
        end
        @(negedge clk);
        chk($sformatf("load%0d_done", n), 32'(done), 32'd1);
        chk($sformatf("load%0d_err_cpurst_busy", n), {29'd0, err, cpu_rst, busy}, 32'd0);
        chk($sformatf("load%0d_pending", n), 32'(exp_q.size()), 32'd0);
    endtask

    // Header-only load whose count must be rejected.
    task automatic bad_header(input logic [7:0] lo, input logic [7:0] hi);
        pulse_start();
        send_byte(lo, 0);
        send_byte(hi, 0);
        chk($sformatf("hdr_%02h%02h_err", lo, hi), 32'(err), 32'd1);
        chk($sformatf("hdr_%02h%02h_cpurst_ready", lo, hi), {30'd0, cpu_rst, rx_ready}, 32'd2);
        repeat (4) @(negedge clk);
        chk($sformatf("hdr_%02h%02h_err_hold", lo, hi), 32'(err), 32'd1);
    endtask

    initial begin
        int idle;
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {25'd0, rx_ready, mem_we, cpu_rst, busy, done, err, 1'b0}, 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);

        // Directed two-word program.
        fixed_q = '{32'h00100093, 32'h00200113};
        run_load(2, 0, 1'b1);

        // Rejected and boundary header counts.
        bad_header(8'h00, 8'h00);
        bad_header(8'h01, 8'h04);
        run_load(1024, 0, 1'b0);

        // Silence in the middle of a word.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 3; k++) send_byte(8'(k + 5), 0);
        idle = 0;
        while (!err && idle < 40) begin
            @(negedge clk);
            idle++;
        end
        chk("timeout_idle_cycles", 32'(idle), 32'(TIMEOUT));
        chk("timeout_cpurst", 32'(cpu_rst), 32'd1);

        // Reset after six bytes of a three-word load.
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        exp_q.push_back('{0, 32'hA1B2C3D4});
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ctrl", {25'd0, rx_ready, mem_we, cpu_rst, busy, done, err, 1'b0}, 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        exp_q.delete();
        run_load(3, 1, 1'b0);

        // Random loads with bursty rx_valid and a stray start mid-load.
        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(12, 1));
            glitch_at = (t % 2 == 0) ? int'($urandom_range(2 + 4 * n - 1, 1)) : -1;
            run_load(n, 3, 1'b0);
        end
        glitch_at = -1;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory address width (1024 words).
REQ-002 Parameter: TIMEOUT, default 50000, maximum idle clock cycles allowed between accepted bytes during a load.
REQ-003 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: start  input  1  single-cycle pulse that begins a load.
REQ-006 Port: rx_data  input  8  incoming program byte.
REQ-007 Port: rx_valid  input  1  rx_data is valid.
REQ-008 Port: rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready.
REQ-009 Port: mem_we  output  1  write strobe to instruction memory.
REQ-010 Port: mem_addr  output  ADDR_W  word address of the write.
REQ-011 Port: mem_wdata  output  32  instruction word to write.
REQ-012 Port: cpu_rst  output  1  holds the processor in reset while memory contents are invalid.
REQ-013 Port: busy  output  1  a load is in progress.
REQ-014 Port: done  output  1  sticky flag: the last load completed.
REQ-015 Port: err  output  1  sticky flag: the last load aborted.

Function
REQ-016 The FSM SHALL have the states IDLE, HDR, DATA, WRITE, DONE and ERR.
REQ-017 Stream format: 2-byte word count N (little-endian), followed by 4*N bytes; each word is little-endian (first byte = bits 7:0).
REQ-018 IDLE/DONE/ERR + start -> HDR; the same cycle clears done, err, byte counter, word index and timeout counter.
REQ-019 rx_ready SHALL be 1 only in HDR and DATA.
REQ-020 In HDR, the second accepted byte latches N; N==0 or N>2**ADDR_W -> ERR, otherwise -> DATA.
REQ-021 In DATA, accepted bytes shift into a 32-bit assembly register; the 4th byte -> WRITE.
REQ-022 WRITE lasts exactly 1 cycle: mem_we=1, mem_addr=word index, mem_wdata=assembled word.
- If word index == N-1 -> DONE.
- Otherwise, word index increments and -> DATA.
REQ-023 Latency: mem_we SHALL assert in the cycle after the 4th byte of a word is accepted; there is one rx_ready bubble per word.
REQ-024 Words SHALL be written to consecutive addresses starting at 0; no address wrap occurs, because N is bounded by REQ-020.
REQ-025 mem_we SHALL be 0 in every state except WRITE.
REQ-026 Timeout counter: increments each cycle in HDR/DATA without a transfer and clears on each transfer; reaching TIMEOUT -> ERR.
REQ-027 busy SHALL be 1 in HDR, DATA and WRITE.
REQ-028 cpu_rst SHALL be 1 in HDR, DATA, WRITE and ERR; 0 in IDLE and DONE.
REQ-029 done=1 in DONE and err=1 in ERR; both hold until the next start or rst.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 ERR SHALL produce no further memory writes; words already written stay in memory.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE from any state, including mid-load.
REQ-033 Values after reset: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=0, busy=0, done=0, err=0; all counters 0.
REQ-034 A load aborted by rst SHALL NOT set err; memory written before the reset is not restored.

Verification
REQ-035 start; bytes 02 00 93 00 10 00 13 01 20 00 -> mem[0]=0x00100093, mem[1]=0x00200113; then done=1 and cpu_rst=0.
REQ-036 start; header 00 00 -> err=1 the cycle after the 2nd byte, mem_we never asserted, cpu_rst=1.
REQ-037 start; header 01 04 (N=1025) -> err=1, no write; header 00 04 (N=1024) is accepted.
REQ-038 TIMEOUT=16; N=1, 3 data bytes then silence -> err=1 after 16 idle cycles, no write.
REQ-039 rst asserted after 6 bytes of a load -> REQ-033 values on the next cycle, err=0; a new start and full load then complete correctly.
REQ-040 rx_valid toggled randomly plus a start pulse mid-load -> start ignored; written words and addresses match a reference model.
